// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweep and compare engine
// Drives every input vector in ascending order, samples dut_f after SETTLE cycles, scores against a latched table.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_f,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   captured,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_err,
  output logic                   first_err_valid
);

  localparam int DEPTH = 1 << N_IN;
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int EW    = N_IN + 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] exp_q;
  logic             sample;
  logic             mismatch;
  logic             last_vec;
  logic [N_IN:0]    err_nx;

  assign sample   = (state == APPLY) && (cnt == CNT_LAST);
  assign mismatch = dut_f != exp_q[stim];
  assign last_vec = stim == STIM_LAST;
  assign err_nx   = err_count + EW'(mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = APPLY;
      end
      APPLY: begin
        busy = 1'b1;
        if (sample && last_vec) state_nx = FINISH;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Results are only cleared on an accepted start so they survive the IDLE gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q           <= '0;
      stim            <= '0;
      cnt             <= '0;
      captured        <= '0;
      err_count       <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
      pass            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q           <= expected;
            stim            <= '0;
            cnt             <= '0;
            captured        <= '0;
            err_count       <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
          end
        end
        APPLY: begin
          if (sample) begin
            cnt             <= '0;
            captured[stim]  <= dut_f;
            err_count       <= err_nx;
            if (mismatch && !first_err_valid) begin
              first_err       <= stim;
              first_err_valid <= 1'b1;
            end
            // pass must include the final vector's result, hence err_nx
            if (last_vec) pass <= (err_nx == '0);
            else          stim <= stim + STIM_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential, parametrised exhaustive-stimulus checker for combinational gate-level functions. On `start` it walks every one of the 2^N_IN input combinations in ascending binary order and holds each one for a programmable settle time. It samples the function-under-test output, assembles the captured truth table and compares it bit-by-bit against an expected truth table. It sits beside gate-level function blocks in lab benches and FPGA self-test wrappers, replacing hand-written 16-line stimulus sequences with a single synthesizable sweep engine.

## Interface
- `N_IN`, default 4: number of function inputs; legal range 1..8.
- `SETTLE`, default 1: clock cycles each stimulus is held before sampling; legal range 1..255.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `expected`  in  2^N_IN  expected truth table; bit i = expected output for stimulus i; latched on accepted `start`.
- `stim`  out  N_IN  stimulus vector driven to the function under test.
- `dut_f`  in  1  function-under-test output; combinational or delayed by fewer than SETTLE cycles.
- `busy`  out  1  high while the sweep runs.
- `done`  out  1  one-cycle pulse when results become valid.
- `pass`  out  1  high when captured equals expected.
- `captured`  out  2^N_IN  sampled truth table.
- `err_count`  out  N_IN+1  number of mismatching entries, from 0 to 2^N_IN.
- `first_err`  out  N_IN  lowest mismatching stimulus index.
- `first_err_valid`  out  1  at least one mismatch found.

## Operation
- FSM states: IDLE, APPLY, FINISH.
- IDLE:
  - `start`=1 → APPLY.
  - Latch `expected`; clear `stim`, settle counter, `captured`, `err_count`, `first_err`, `first_err_valid` and `pass`.
- APPLY:
  - Settle counter counts 0..SETTLE-1.
  - On the edge where the counter equals SETTLE-1:
    - Write `dut_f` into `captured[stim]`.
    - If `dut_f` ≠ `expected[stim]`: increment `err_count`. If `first_err_valid`=0, load `first_err`=`stim` and set `first_err_valid`=1.
    - Reset the settle counter.
    - If `stim`=2^N_IN-1 → FINISH. Otherwise increment `stim`.
- FINISH (one cycle):
  - `done`=1, `busy`=0.
  - `pass` = (`err_count`==0), registered on the FINISH entry edge.
  - → IDLE.
- Results (`captured`, `err_count`, `first_err*`, `pass`) hold until the next accepted `start`.
- `stim` holds its last value (2^N_IN-1) after the sweep.
- The mismatch test uses the latched copy of `expected`. Changing the port mid-sweep has no effect.
- `err_count` never wraps: N_IN+1 bits hold 2^N_IN exactly.
- `stim` wrap-around does not occur; the sweep ends at the all-ones vector.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - `stim`, `busy`, `done`, `pass`, `captured`, `err_count`, `first_err`, `first_err_valid` all 0.
  - `rst` wins over every other event.
- `start` accepted at edge k:
  - `busy`=1 and `stim`=0 from edge k.
  - Vector i is driven from edge k+i·SETTLE and sampled at edge k+(i+1)·SETTLE.
  - Last sample (FINISH entry) at edge k+2^N_IN·SETTLE, with `busy`→0 and `done`→1.
  - `done`→0 at the next edge.
- `start` during APPLY/FINISH is ignored, with no restart.
- `start` held high continuously gives back-to-back sweeps, one IDLE cycle between a `done` pulse and the next `busy`.
- `rst` mid-sweep aborts without a `done` pulse. The next `start` performs a complete fresh sweep.

## Test plan
- N_IN=4, SETTLE=1, `dut_f`=^`stim`, `expected`=16'h6996, `start` pulsed at edge k:
  - `busy` high for 16 cycles.
  - `done` pulse at edge k+16.
  - `captured`=16'h6996, `err_count`=0, `pass`=1, `first_err_valid`=0.
- Same DUT, `expected`=16'h6996^16'h8101 → `err_count`=3, `first_err`=0, `first_err_valid`=1, `pass`=0. With `expected`=16'h6996^16'h8100 → `err_count`=2, `first_err`=8.
- SETTLE=3, `dut_f` = parity of `stim` delayed by two registers, `expected`=16'h6996 → `pass`=1, `done` at edge k+48, each `stim` value held exactly 3 cycles.
- Assert `rst` asynchronously while `stim`=7:
  - All outputs read 0 before the next edge.
  - `done` never pulses.
  - A following `start` gives a complete 16-vector sweep with `pass`=1.
- `start` held high for 40 cycles (N_IN=4, SETTLE=1) → two full sweeps, `done` pulses at k+16 and k+34. A single `start` pulse during a sweep leaves its timing unchanged.
- N_IN=1, `dut_f`=`stim[0]`, `expected`=2'b01 → `err_count`=2 (full width, no wrap), `first_err`=0, `pass`=0, `captured`=2'b10.
